// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl_if
//  Purpose  : Bundles the core-side request/response handshake and the
//             data-memory port of the load/store controller.
//  Modports : slave  - controller view (drives req_ready, rsp_*, dmem_* outs)
//             master - core + memory view (drives req_*, rsp_ready, dmem_rdata)
//  Signals  : req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3
//             rsp_valid/rsp_ready/rsp_rdata/rsp_err
//             dmem_addr/dmem_wdata/dmem_size/dmem_wen/dmem_rdata
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [2:0]        req_funct3;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [2:0]        dmem_size;
   logic              dmem_wen;
   logic [DATA_W-1:0] dmem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  rsp_ready, dmem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output dmem_addr, dmem_wdata, dmem_size, dmem_wen
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      output rsp_ready, dmem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  dmem_addr, dmem_wdata, dmem_size, dmem_wen
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_ctrl
//  Purpose  : Load/store controller between the MEM stage and a byte-addressed
//             data memory with a one-cycle registered read. Checks funct3
//             legality and alignment, performs the access, registers the
//             result and holds it until the core accepts the response.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - lsu_mem_ctrl_if.slave (request, response, memory port)
//  Options  : LSU_MISALIGN_SPLIT_EN - when defined, misaligned H/HU/W accesses
//             are split into byte accesses instead of returning an error.
//  Notes    : DATA_W must be 32.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   lsu_mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_CAPT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;
   logic [2:0]        msize_q, msize_d;
   logic              mwen_q, mwen_d;

   logic              legal_w;
   logic              aligned_w;
   logic              error_w;

`ifdef LSU_MISALIGN_SPLIT_EN
   // Request copy needed to generate the follow-on byte accesses.
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic              split_q, split_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] asm_q, asm_d;

   logic [1:0]        last_w;
   logic [1:0]        cnt_nx_w;
   logic [DATA_W-1:0] asm_w;
   logic [DATA_W-1:0] ext_w;
`endif

   // Legality and natural alignment of the incoming request.
   always_comb begin
      legal_w = 1'b0;
      if (bus.req_we) begin
         legal_w = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                   (bus.req_funct3 == F3_W);
      end else begin
         legal_w = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H)  ||
                   (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                   (bus.req_funct3 == F3_HU);
      end

      aligned_w = 1'b1;
      case (bus.req_funct3)
         F3_H, F3_HU: aligned_w = ~bus.req_addr[0];
         F3_W:        aligned_w = (bus.req_addr[1:0] == 2'b00);
         default:     aligned_w = 1'b1;
      endcase

`ifdef LSU_MISALIGN_SPLIT_EN
      error_w = ~legal_w;
`else
      error_w = ~legal_w | ~aligned_w;
`endif
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   // Byte-split helpers: last byte index, next index, assembled word
   // (current byte merged in) and its final extension.
   always_comb begin
      last_w   = (f3_q == F3_W) ? 2'd3 : 2'd1;
      cnt_nx_w = cnt_q + 2'd1;
      asm_w    = asm_q;
      asm_w[{cnt_q, 3'b000} +: 8] = bus.dmem_rdata[7:0];
      case (f3_q)
         F3_H:    ext_w = {{16{asm_w[15]}}, asm_w[15:0]};
         F3_HU:   ext_w = {16'h0000, asm_w[15:0]};
         default: ext_w = asm_w;
      endcase
   end
`endif

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      msize_d  = msize_q;
      mwen_d   = 1'b0;          // write strobe only lives for one ACCESS cycle
`ifdef LSU_MISALIGN_SPLIT_EN
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      f3_d     = f3_q;
      split_d  = split_q;
      cnt_d    = cnt_q;
      asm_d    = asm_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d = bus.req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               f3_d    = bus.req_funct3;
               split_d = ~aligned_w;
               cnt_d   = 2'd0;
               asm_d   = '0;
`endif
               if (error_w) begin
                  // No memory access; memory port keeps its last values.
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = ST_RESP;
               end
`ifdef LSU_MISALIGN_SPLIT_EN
               else if (!aligned_w) begin
                  // First byte of a split access.
                  err_d    = 1'b0;
                  maddr_d  = bus.req_addr;
                  msize_d  = bus.req_we ? F3_B : F3_BU;
                  mwdata_d = {{(DATA_W-8){1'b0}}, bus.req_wdata[7:0]};
                  mwen_d   = bus.req_we;
                  state_d  = ST_ACCESS;
               end
`endif
               else begin
                  err_d    = 1'b0;
                  maddr_d  = bus.req_addr;
                  msize_d  = bus.req_funct3;
                  mwdata_d = bus.req_wdata;
                  mwen_d   = bus.req_we;
                  state_d  = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            state_d = ST_CAPT;
         end

         ST_CAPT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (split_q) begin
               asm_d = asm_w;
               if (cnt_q == last_w) begin
                  rdata_d = we_q ? '0 : ext_w;
                  state_d = ST_RESP;
               end else begin
                  cnt_d    = cnt_nx_w;
                  maddr_d  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_nx_w};
                  mwdata_d = {{(DATA_W-8){1'b0}}, wdata_q[{cnt_nx_w, 3'b000} +: 8]};
                  mwen_d   = we_q;
                  state_d  = ST_ACCESS;
               end
            end else
`endif
            begin
               // Memory already returns the load extended per size.
               rdata_d = we_q ? '0 : bus.dmem_rdata;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         msize_q  <= F3_W;
         mwen_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         addr_q   <= '0;
         wdata_q  <= '0;
         f3_q     <= F3_W;
         split_q  <= 1'b0;
         cnt_q    <= 2'd0;
         asm_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         msize_q  <= msize_d;
         mwen_q   <= mwen_d;
`ifdef LSU_MISALIGN_SPLIT_EN
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         f3_q     <= f3_d;
         split_q  <= split_d;
         cnt_q    <= cnt_d;
         asm_q    <= asm_d;
`endif
      end
   end

   // Handshakes decode straight from the state register, so req_ready is
   // already low in the cycle RESP is being left.
   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.rsp_valid  = (state_q == ST_RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_err    = err_q;
   assign bus.dmem_addr  = maddr_q;
   assign bus.dmem_wdata = mwdata_q;
   assign bus.dmem_size  = msize_q;
   assign bus.dmem_wen   = mwen_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_ctrl
//  Purpose  : Self-checking bench for lsu_mem_ctrl with a byte-array memory
//             model (one-cycle registered read, size-extended data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wen;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   logic mem_clr;
   int   checks;
   int   errors;

   lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------ memory
   logic [7:0] mem [0:1023];
   logic [9:0] wa0, wa1, wa2, wa3;
   assign wa0 = bus.dmem_addr[9:0];
   assign wa1 = bus.dmem_addr[9:0] + 10'd1;
   assign wa2 = bus.dmem_addr[9:0] + 10'd2;
   assign wa3 = bus.dmem_addr[9:0] + 10'd3;

   function automatic logic [31:0] mem_rd(input logic [2:0] s, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3);
      case (s)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b100:  return {24'h0, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (bus.dmem_wen) begin
         mem[wa0] <= bus.dmem_wdata[7:0];
         if (bus.dmem_size[1:0] != 2'b00) mem[wa1] <= bus.dmem_wdata[15:8];
         if (bus.dmem_size[1:0] == 2'b10) begin
            mem[wa2] <= bus.dmem_wdata[23:16];
            mem[wa3] <= bus.dmem_wdata[31:24];
         end
      end
      bus.dmem_rdata <= mem_rd(bus.dmem_size, mem[wa0], mem[wa1], mem[wa2], mem[wa3]);
   end

   // -------------------------------------------------------- write strobe log
   int          wen_total;
   logic [31:0] wen_addr_log  [0:63];
   logic [31:0] wen_wdata_log [0:63];
   logic [2:0]  wen_size_log  [0:63];

   initial wen_total = 0;
   always @(negedge clk) begin
      if (bus.dmem_wen) begin
         if (wen_total < 64) begin
            wen_addr_log[wen_total]  <= bus.dmem_addr;
            wen_wdata_log[wen_total] <= bus.dmem_wdata;
            wen_size_log[wen_total]  <= bus.dmem_size;
         end
         wen_total <= wen_total + 1;
      end
   end

   // ------------------------------------------------------------- checking
   exp_t sb[$];
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Wait (bounded) for rsp_valid, counting cycles from the accept edge.
   task automatic wait_rsp(output int lat, output bit got);
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) got = 1'b1;
         else lat++;
      end
   endtask

   task automatic run_req(input vec_t v, input string tag);
      exp_t e;
      int   lat;
      bit   got;
      int   w0;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.lat   = v.exp_lat;
      sb.push_back(e);
      @(negedge clk);
      w0 = wen_total;
      chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
      bus.req_we     = v.we;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      bus.req_funct3 = v.f3;
      bus.req_valid  = 1'b1;
      bus.rsp_ready  = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      wait_rsp(lat, got);
      e = sb.pop_front();
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_rsp_valid expected=rsp_valid", tag);
      end else begin
         chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
         chk({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
         chk({tag, "_lat"}, lat, e.lat);
      end
      chk({tag, "_wen_count"}, wen_total - w0, v.exp_wen);
      if (v.exp_wen == 1 && wen_total - w0 == 1) begin
         chk({tag, "_wen_addr"}, wen_addr_log[w0], v.addr);
         chk({tag, "_wen_size"}, {29'b0, wen_size_log[w0]}, {29'b0, v.f3});
         chk({tag, "_wen_wdata"}, wen_wdata_log[w0], v.wdata);
      end else if (v.exp_wen > 1 && wen_total - w0 == v.exp_wen) begin
         for (int i = 0; i < v.exp_wen; i++) begin
            logic [31:0] sh;
            sh = v.wdata >> (8 * i);
            chk({tag, "_split_addr"}, wen_addr_log[w0 + i], v.addr + i);
            chk({tag, "_split_size"}, {29'b0, wen_size_log[w0 + i]}, 32'd0);
            chk({tag, "_split_byte"}, {24'b0, wen_wdata_log[w0 + i][7:0]}, {24'b0, sh[7:0]});
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   lat;
      bit   got;
      int   w0;
      logic [31:0] held;

      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      mem_clr        = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = 3'b010;
      bus.rsp_ready  = 1'b0;

      //            we    addr        wdata         f3      rdata         err  lat wen
      vecs.push_back(vec_t'{1'b1, 32'h100, 32'hCAFEBABE, 3'b010, 32'h00000000, 1'b0, 3, 1});
      vecs.push_back(vec_t'{1'b0, 32'h100, 32'h0,        3'b010, 32'hCAFEBABE, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b1, 32'h203, 32'h00000080, 3'b000, 32'h00000000, 1'b0, 3, 1});
      vecs.push_back(vec_t'{1'b0, 32'h203, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b0, 32'h203, 32'h0,        3'b100, 32'h00000080, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b1, 32'h204, 32'h1234ABCD, 3'b001, 32'h00000000, 1'b0, 3, 1});
      vecs.push_back(vec_t'{1'b0, 32'h204, 32'h0,        3'b001, 32'hFFFFABCD, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b0, 32'h204, 32'h0,        3'b101, 32'h0000ABCD, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b0, 32'h200, 32'h0,        3'b010, 32'h80000000, 1'b0, 3, 0});
      vecs.push_back(vec_t'{1'b1, 32'h300, 32'h55555555, 3'b100, 32'h00000000, 1'b1, 1, 0});
      vecs.push_back(vec_t'{1'b0, 32'h300, 32'h0,        3'b011, 32'h00000000, 1'b1, 1, 0});
      vecs.push_back(vec_t'{1'b1, 32'h300, 32'h55555555, 3'b101, 32'h00000000, 1'b1, 1, 0});
`ifndef LSU_MISALIGN_SPLIT_EN
      vecs.push_back(vec_t'{1'b0, 32'h101, 32'h0,        3'b001, 32'h00000000, 1'b1, 1, 0});
      vecs.push_back(vec_t'{1'b0, 32'h102, 32'h0,        3'b010, 32'h00000000, 1'b1, 1, 0});
      vecs.push_back(vec_t'{1'b1, 32'h102, 32'h77777777, 3'b010, 32'h00000000, 1'b1, 1, 0});
      vecs.push_back(vec_t'{1'b1, 32'h205, 32'h77777777, 3'b001, 32'h00000000, 1'b1, 1, 0});
`else
      vecs.push_back(vec_t'{1'b0, 32'h101, 32'h0,        3'b001, 32'hFFFFFEBA, 1'b0, 5, 0});
      vecs.push_back(vec_t'{1'b0, 32'h101, 32'h0,        3'b101, 32'h0000FEBA, 1'b0, 5, 0});
      vecs.push_back(vec_t'{1'b0, 32'h102, 32'h0,        3'b010, 32'h0000CAFE, 1'b0, 9, 0});
`endif

      repeat (3) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      rst     = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready",  {31'b0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid",  {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata",  bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err",    {31'b0, bus.rsp_err}, 32'd0);
      chk("rst_dmem_addr",  bus.dmem_addr, 32'd0);
      chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
      chk("rst_dmem_size",  {29'b0, bus.dmem_size}, 32'd2);
      chk("rst_dmem_wen",   {31'b0, bus.dmem_wen}, 32'd0);

      foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

      // Response held with rsp_ready low while a second request waits.
      e.rdata = 32'hCAFEBABE;
      e.err   = 1'b0;
      e.lat   = 3;
      sb.push_back(e);
      @(negedge clk);
      w0 = wen_total;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h100;
      bus.req_funct3 = 3'b010;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_we     = 1'b1;        // pending store that must not be taken
      bus.req_addr   = 32'h300;
      bus.req_wdata  = 32'hDEADBEEF;
      wait_rsp(lat, got);
      e = sb.pop_front();
      chk("hold_got", {31'b0, got}, 32'd1);
      chk("hold_lat", lat, e.lat);
      held = bus.rsp_rdata;
      chk("hold_rdata", held, e.rdata);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid_stable", {31'b0, bus.rsp_valid}, 32'd1);
         chk("hold_rdata_stable", bus.rsp_rdata, e.rdata);
         chk("hold_err_stable",   {31'b0, bus.rsp_err}, 32'd0);
         chk("hold_req_ready",    {31'b0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("hold_exit_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("hold_exit_ready", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      chk("hold_no_wen", wen_total - w0, 32'd0);

      // Reset while a load sits in CAPT; its response is discarded.
      @(negedge clk);
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h100;
      bus.req_funct3 = 3'b010;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      @(negedge clk);                 // ACCESS
      @(negedge clk);                 // CAPT
      chk("capt_req_ready", {31'b0, bus.req_ready}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_mid_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_mid_size",  {29'b0, bus.dmem_size}, 32'd2);
      run_req(vec_t'{1'b0, 32'h100, 32'h0, 3'b010, 32'hCAFEBABE, 1'b0, 3, 0}, "after_rst");

`ifdef LSU_MISALIGN_SPLIT_EN
      run_req(vec_t'{1'b1, 32'h101, 32'h11223344, 3'b010, 32'h0,        1'b0, 9, 4}, "split_st_w");
      run_req(vec_t'{1'b0, 32'h101, 32'h0,        3'b010, 32'h11223344, 1'b0, 9, 0}, "split_ld_w");
      run_req(vec_t'{1'b1, 32'h103, 32'h00000033, 3'b000, 32'h0,        1'b0, 3, 1}, "st_b33");
      run_req(vec_t'{1'b1, 32'h104, 32'h00000082, 3'b000, 32'h0,        1'b0, 3, 1}, "st_b82");
      run_req(vec_t'{1'b0, 32'h103, 32'h0,        3'b001, 32'hFFFF8233, 1'b0, 5, 0}, "split_ld_h");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
